// File: rtl/mem_stage.sv
// MEM pipeline stage: issues load/store requests on a valid/ready data-memory port,
// aligns store lanes, extends load data, stalls while a request is open, and feeds MEM->WB.
module mem_stage #(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mem_pc,
  input  logic [31:0]      mem_alu,
  input  logic [31:0]      mem_rd2,
  input  logic [31:0]      mem_inst,
  input  logic             mem_br_suc,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_we,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_rsp_valid,
  input  logic [31:0]      dmem_rsp_data,
  output logic             mem_stall,
  output logic             mem_misalign,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_alu,
  output logic [31:0]      wb_ldata,
  output logic [31:0]      wb_inst,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_hits
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_is_branch;
  logic             w_fault;
  logic             w_mem_op;
  logic             w_req_valid;
  logic             w_stall;
  logic [3:0]       w_we;
  logic [31:0]      w_wdata;
  logic [31:0]      w_shifted;
  logic [31:0]      w_ldata;
  logic             w_unused;
  logic [CNT_W-1:0] w_cnt_one;
  logic [CNT_W-1:0] w_cnt_max;

  logic             r_misalign;
  logic [31:0]      r_wb_pc;
  logic [31:0]      r_wb_alu;
  logic [31:0]      r_wb_ldata;
  logic [31:0]      r_wb_inst;
  logic [CNT_W-1:0] r_br_total;
  logic [CNT_W-1:0] r_br_hits;

  assign w_opcode    = mem_inst[6:0];
  assign w_funct3    = mem_inst[14:12];
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_mem_op    = (w_is_load | w_is_store) & ~w_fault;
  assign w_unused    = ^{mem_inst[31:15], mem_inst[11:7]};
  assign w_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_cnt_max   = {CNT_W{1'b1}};

  // Misaligned halfword/word accesses and unsupported funct3 codes are dropped as faults.
  always_comb begin
    w_fault = 1'b0;
    if (w_is_load) begin
      case (w_funct3)
        3'b000, 3'b100: w_fault = 1'b0;
        3'b001, 3'b101: w_fault = mem_alu[0];
        3'b010:         w_fault = |mem_alu[1:0];
        default:        w_fault = 1'b1;
      endcase
    end else if (w_is_store) begin
      case (w_funct3)
        3'b000:  w_fault = 1'b0;
        3'b001:  w_fault = mem_alu[0];
        3'b010:  w_fault = |mem_alu[1:0];
        default: w_fault = 1'b1;
      endcase
    end else begin
      w_fault = 1'b0;
    end
  end

  // FSM next state plus request/stall; reset forces both low without waiting for a clock.
  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_stall     = 1'b0;
    if (rst) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op) begin
            w_req_valid = 1'b1;
            if (dmem_req_ready) begin
              if (w_is_load) begin
                w_stall     = 1'b1;
                w_state_nxt = ST_WAIT;
              end else begin
                w_stall = 1'b0;
              end
            end else begin
              w_stall = 1'b1;
            end
          end else begin
            w_req_valid = 1'b0;
          end
        end
        ST_WAIT: begin
          if (dmem_rsp_valid) begin
            w_stall     = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stall = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Store data is replicated across lanes; the enables pick the addressed bytes.
  always_comb begin
    w_we    = 4'b0000;
    w_wdata = 32'h0000_0000;
    if (w_is_store) begin
      case (w_funct3)
        3'b000: begin
          w_wdata = {4{mem_rd2[7:0]}};
          w_we    = 4'b0001 << mem_alu[1:0];
        end
        3'b001: begin
          w_wdata = {2{mem_rd2[15:0]}};
          w_we    = 4'b0011 << {mem_alu[1], 1'b0};
        end
        3'b010: begin
          w_wdata = mem_rd2;
          w_we    = 4'b1111;
        end
        default: begin
          w_wdata = 32'h0000_0000;
          w_we    = 4'b0000;
        end
      endcase
    end else begin
      w_we    = 4'b0000;
      w_wdata = 32'h0000_0000;
    end
  end

  assign w_shifted = dmem_rsp_data >> {mem_alu[1:0], 3'b000};

  // Load extension from the byte-shifted response word.
  always_comb begin
    w_ldata = 32'h0000_0000;
    case (w_funct3)
      3'b000:  w_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_ldata = w_shifted;
      3'b100:  w_ldata = {24'h00_0000, w_shifted[7:0]};
      3'b101:  w_ldata = {16'h0000, w_shifted[15:0]};
      default: w_ldata = 32'h0000_0000;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // MEM->WB boundary: a stall inserts a bubble while the data fields hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_pc    <= 32'h0000_0000;
      r_wb_alu   <= 32'h0000_0000;
      r_wb_ldata <= 32'h0000_0000;
      r_wb_inst  <= NOP_INST;
      r_misalign <= 1'b0;
    end else if (!w_stall) begin
      r_wb_pc    <= mem_pc;
      r_wb_alu   <= mem_alu;
      r_wb_ldata <= (w_is_load && !w_fault) ? w_ldata : 32'h0000_0000;
      r_wb_inst  <= w_fault ? NOP_INST : mem_inst;
      r_misalign <= w_fault;
    end else begin
      r_wb_inst  <= NOP_INST;
      r_misalign <= 1'b0;
    end
  end

  // Saturating branch statistics, counted only when the branch actually retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_total <= {CNT_W{1'b0}};
      r_br_hits  <= {CNT_W{1'b0}};
    end else if (!w_stall && w_is_branch) begin
      if (r_br_total != w_cnt_max) begin
        r_br_total <= r_br_total + w_cnt_one;
      end
      if (mem_br_suc && (r_br_hits != w_cnt_max)) begin
        r_br_hits <= r_br_hits + w_cnt_one;
      end
    end
  end

  assign dmem_req_valid = w_req_valid;
  assign dmem_addr      = {mem_alu[31:2], 2'b00};
  assign dmem_we        = w_req_valid ? w_we : 4'b0000;
  assign dmem_wdata     = w_wdata;
  assign mem_stall      = w_stall;
  assign mem_misalign   = r_misalign;
  assign wb_pc          = r_wb_pc;
  assign wb_alu         = r_wb_alu;
  assign wb_ldata       = r_wb_ldata;
  assign wb_inst        = r_wb_inst;
  assign br_total       = r_br_total;
  assign br_hits        = r_br_hits;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single transactions plus hand-written
// multi-cycle sequences (held request, load wait, branch stats, reset in WAIT).
module tb_mem_stage;
  localparam int          CNT_W = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [6:0]  OPL   = 7'b0000011;
  localparam logic [6:0]  OPS   = 7'b0100011;
  localparam logic [6:0]  OPB   = 7'b1100011;
  localparam logic [6:0]  OPI   = 7'b0010011;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      mem_pc, mem_alu, mem_rd2, mem_inst;
  logic             mem_br_suc;
  logic             dmem_req_valid, dmem_req_ready;
  logic [31:0]      dmem_addr;
  logic [3:0]       dmem_we;
  logic [31:0]      dmem_wdata;
  logic             dmem_rsp_valid;
  logic [31:0]      dmem_rsp_data;
  logic             mem_stall, mem_misalign;
  logic [31:0]      wb_pc, wb_alu, wb_ldata, wb_inst;
  logic [CNT_W-1:0] br_total, br_hits;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.CNT_W(CNT_W), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .mem_pc(mem_pc), .mem_alu(mem_alu), .mem_rd2(mem_rd2), .mem_inst(mem_inst),
    .mem_br_suc(mem_br_suc),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign),
    .wb_pc(wb_pc), .wb_alu(wb_alu), .wb_ldata(wb_ldata), .wb_inst(wb_inst),
    .br_total(br_total), .br_hits(br_hits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] rdata;
    logic        req;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic        mis;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0_0000, f3, 5'h03, op};
  endfunction

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] alu,
                              input logic [31:0] rd2, input logic [31:0] rdata,
                              input logic req, input logic [3:0] we,
                              input logic [31:0] wdata, input logic [31:0] ldata,
                              input logic mis);
    vec_t v;
    v.inst = inst; v.alu = alu; v.rd2 = rd2; v.rdata = rdata; v.req = req;
    v.we = we; v.wdata = wdata; v.ldata = ldata; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic suc, input logic [31:0] pc);
    mem_inst = inst; mem_alu = alu; mem_rd2 = rd2; mem_br_suc = suc; mem_pc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic suc);
    drive(enc(OPB, 3'b000), 32'h0000_0000, 32'h0000_0000, suc, 32'h0000_2000);
    #1;
    chk("branch no stall", 32'(mem_stall), 32'h0);
    step();
  endtask

  logic [31:0] lw_i, sh_i, br_i;
  logic [31:0] exp_pc;
  int          n_stall, n_req, n_wb, n_bad;
  logic        done;
  logic        is_ld;

  initial begin
    lw_i = enc(OPL, 3'b010);
    sh_i = enc(OPS, 3'b001);
    br_i = enc(OPB, 3'b000);

    vt.push_back(mk(lw_i,              32'h100, 32'h0,        32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0));
    vt.push_back(mk(enc(OPL, 3'b000), 32'h103, 32'h0,        32'h80FF_FFFF, 1'b1, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0));
    vt.push_back(mk(enc(OPL, 3'b100), 32'h103, 32'h0,        32'h80FF_FFFF, 1'b1, 4'b0000, 32'h0, 32'h0000_0080, 1'b0));
    vt.push_back(mk(enc(OPL, 3'b001), 32'h102, 32'h0,        32'h8001_1234, 1'b1, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0));
    vt.push_back(mk(enc(OPL, 3'b101), 32'h102, 32'h0,        32'h8001_1234, 1'b1, 4'b0000, 32'h0, 32'h0000_8001, 1'b0));
    vt.push_back(mk(enc(OPL, 3'b000), 32'h101, 32'h0,        32'h0000_7F00, 1'b1, 4'b0000, 32'h0, 32'h0000_007F, 1'b0));
    vt.push_back(mk(enc(OPL, 3'b001), 32'h100, 32'h0,        32'h0000_F00F, 1'b1, 4'b0000, 32'h0, 32'hFFFF_F00F, 1'b0));
    vt.push_back(mk(enc(OPS, 3'b000), 32'h101, 32'h1122_3344, 32'h0,        1'b1, 4'b0010, 32'h4444_4444, 32'h0, 1'b0));
    vt.push_back(mk(sh_i,              32'h102, 32'h1234_ABCD, 32'h0,        1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0));
    vt.push_back(mk(sh_i,              32'h100, 32'h1234_ABCD, 32'h0,        1'b1, 4'b0011, 32'hABCD_ABCD, 32'h0, 1'b0));
    vt.push_back(mk(enc(OPS, 3'b010), 32'h104, 32'hCAFE_F00D, 32'h0,        1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0));
    vt.push_back(mk(enc(OPS, 3'b000), 32'h103, 32'h0000_00A5, 32'h0,        1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0));
    vt.push_back(mk(lw_i,              32'h101, 32'h0,        32'h1111_1111, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1));
    vt.push_back(mk(enc(OPL, 3'b001), 32'h103, 32'h0,        32'h1111_1111, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1));
    vt.push_back(mk(enc(OPS, 3'b010), 32'h102, 32'h5555_5555, 32'h0,        1'b0, 4'b0000, 32'h0, 32'h0, 1'b1));
    vt.push_back(mk(enc(OPL, 3'b011), 32'h100, 32'h0,        32'h1111_1111, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1));
    vt.push_back(mk(enc(OPS, 3'b011), 32'h100, 32'h5555_5555, 32'h0,        1'b0, 4'b0000, 32'h0, 32'h0, 1'b1));
    vt.push_back(mk(enc(OPI, 3'b000), 32'h055, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0, 32'h0, 1'b0));
    vt.push_back(mk(lw_i,              32'h108, 32'h0,        32'h1234_5678, 1'b1, 4'b0000, 32'h0, 32'h1234_5678, 1'b0));

    rst = 1'b1;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = 32'h0;
    drive(NOP, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) step();
    chk("rst wb_inst", wb_inst, NOP);
    chk("rst wb_pc", wb_pc, 32'h0);
    chk("rst wb_ldata", wb_ldata, 32'h0);
    chk("rst misalign", 32'(mem_misalign), 32'h0);
    chk("rst stall", 32'(mem_stall), 32'h0);
    chk("rst br_total", 32'(br_total), 32'h0);
    rst = 1'b0;
    dmem_req_ready = 1'b1;
    step();

    for (int i = 0; i < vt.size(); i++) begin
      exp_pc = 32'h1000 + 32'(i * 4);
      drive(vt[i].inst, vt[i].alu, vt[i].rd2, 1'b0, exp_pc);
      dmem_rsp_valid = 1'b0;
      #1;
      is_ld = vt[i].req && (vt[i].inst[6:0] == OPL);
      chk($sformatf("v%0d req_valid", i), 32'(dmem_req_valid), 32'(vt[i].req));
      if (vt[i].req) begin
        chk($sformatf("v%0d addr", i), dmem_addr, {vt[i].alu[31:2], 2'b00});
        chk($sformatf("v%0d we", i), 32'(dmem_we), 32'(vt[i].we));
        if (!is_ld) chk($sformatf("v%0d wdata", i), dmem_wdata, vt[i].wdata);
      end
      chk($sformatf("v%0d stall", i), 32'(mem_stall), 32'(is_ld));
      if (is_ld) begin
        step();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = vt[i].rdata;
        #1;
        chk($sformatf("v%0d rsp stall", i), 32'(mem_stall), 32'h0);
        chk($sformatf("v%0d wait req", i), 32'(dmem_req_valid), 32'h0);
      end
      step();
      dmem_rsp_valid = 1'b0;
      chk($sformatf("v%0d wb_inst", i), wb_inst, vt[i].mis ? NOP : vt[i].inst);
      chk($sformatf("v%0d wb_ldata", i), wb_ldata, vt[i].ldata);
      chk($sformatf("v%0d wb_pc", i), wb_pc, exp_pc);
      chk($sformatf("v%0d misalign", i), 32'(mem_misalign), 32'(vt[i].mis));
      drive(NOP, 32'h0, 32'h0, 1'b0, 32'h0);
      step();
      chk($sformatf("v%0d misalign drop", i), 32'(mem_misalign), 32'h0);
      chk($sformatf("v%0d nop wb", i), wb_inst, NOP);
    end

    // Load with response three cycles after acceptance.
    drive(lw_i, 32'h100, 32'h0, 1'b0, 32'h3000);
    dmem_rsp_data = 32'hDEAD_BEEF;
    n_stall = 0; n_req = 0; n_wb = 0; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      dmem_rsp_valid = (c == 3);
      #1;
      if (mem_stall) n_stall++;
      if (dmem_req_valid) n_req++;
      if (!mem_stall) done = 1'b1;
      step();
      if (wb_inst == lw_i) n_wb++;
    end
    dmem_rsp_valid = 1'b0;
    chk("lw done", 32'(done), 32'h1);
    chk("lw wb_ldata", wb_ldata, 32'hDEAD_BEEF);
    drive(NOP, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    if (wb_inst == lw_i) n_wb++;
    chk("lw stall cycles", 32'(n_stall), 32'd3);
    chk("lw req cycles", 32'(n_req), 32'd1);
    chk("lw wb count", 32'(n_wb), 32'd1);

    // Response outside WAIT is ignored.
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hFFFF_FFFF;
    #1;
    chk("stray rsp stall", 32'(mem_stall), 32'h0);
    step();
    chk("stray rsp ldata", wb_ldata, 32'h0);
    dmem_rsp_valid = 1'b0;

    // Store held while ready is low for two cycles.
    drive(sh_i, 32'h102, 32'h1234_ABCD, 1'b0, 32'h3100);
    n_stall = 0; n_req = 0; n_bad = 0; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      dmem_req_ready = (c >= 2);
      #1;
      if (dmem_req_valid) begin
        n_req++;
        if (dmem_we !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD) n_bad++;
      end
      if (mem_stall) n_stall++;
      if (!mem_stall) done = 1'b1;
      step();
    end
    chk("sh done", 32'(done), 32'h1);
    chk("sh req cycles", 32'(n_req), 32'd3);
    chk("sh stall cycles", 32'(n_stall), 32'd2);
    chk("sh lane errors", 32'(n_bad), 32'd0);
    chk("sh wb_inst", wb_inst, sh_i);
    dmem_req_ready = 1'b1;
    drive(NOP, 32'h0, 32'h0, 1'b0, 32'h0);
    step();

    // Branch statistics, including a branch seen only while stalled.
    branch(1'b1);
    branch(1'b0);
    chk("br total 2", 32'(br_total), 32'd2);
    chk("br hits 1", 32'(br_hits), 32'd1);
    drive(lw_i, 32'h100, 32'h0, 1'b0, 32'h3200);
    step();
    for (int c = 0; c < 2; c++) begin
      drive(br_i, 32'h0, 32'h0, 1'b1, 32'h3204);
      #1;
      chk("br held stall", 32'(mem_stall), 32'h1);
      step();
    end
    chk("br held total", 32'(br_total), 32'd2);
    chk("br held hits", 32'(br_hits), 32'd1);
    drive(lw_i, 32'h100, 32'h0, 1'b0, 32'h3200);
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h0;
    step();
    dmem_rsp_valid = 1'b0;
    branch(1'b1);
    chk("br total 3", 32'(br_total), 32'd3);
    chk("br hits 2", 32'(br_hits), 32'd2);
    branch(1'b1);
    branch(1'b1);
    chk("br total sat", 32'(br_total), 32'd3);
    chk("br hits sat", 32'(br_hits), 32'd3);

    // Reset while waiting for a load response.
    drive(lw_i, 32'h104, 32'h0, 1'b0, 32'h3300);
    #1;
    chk("rw accept stall", 32'(mem_stall), 32'h1);
    step();
    rst = 1'b1;
    #1;
    chk("rw stall", 32'(mem_stall), 32'h0);
    chk("rw req", 32'(dmem_req_valid), 32'h0);
    chk("rw wb_pc", wb_pc, 32'h0);
    chk("rw br_total", 32'(br_total), 32'h0);
    step();
    rst = 1'b0;
    drive(NOP, 32'h0, 32'h0, 1'b0, 32'h0);
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hFFFF_FFFF;
    #1;
    chk("rw post stall", 32'(mem_stall), 32'h0);
    step();
    dmem_rsp_valid = 1'b0;
    chk("rw ldata", wb_ldata, 32'h0);
    chk("rw wb_inst", wb_inst, NOP);
    chk("rw misalign", 32'(mem_misalign), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
